// File: rtl/sync_tx_arbiter_pkg.sv
// Shared types and helpers for the synchronizer-channel source-side arbiter.
package sync_tx_arbiter_pkg;

  // Transfer sequencing: accept in idle, flip the enable level, then hold the bus.
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StLaunch = 2'b01,
    StHold   = 2'b10
  } state_e;

  // Requester identifiers as reported on last_src.
  localparam logic SrcA = 1'b0;
  localparam logic SrcB = 1'b1;

  // Ceiling log2, never less than 1, so a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_tx_arbiter_if.sv
// Requester handshakes and synchronizer-facing bus for the source-side arbiter.
interface sync_tx_arbiter_if #(
  parameter int unsigned Width = 8
) ();

  logic             a_valid;
  logic [Width-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [Width-1:0] b_data;
  logic             b_ready;
  logic [Width-1:0] tx_bus;
  logic             tx_toggle;
  logic             busy;
  logic             last_src;

  // Requester / observer side.
  modport master (
    output a_valid, a_data, b_valid, b_data,
    input  a_ready, b_ready, tx_bus, tx_toggle, busy, last_src
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_data, b_valid, b_data,
    output a_ready, b_ready, tx_bus, tx_toggle, busy, last_src
  );

endinterface

// File: rtl/sync_tx_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant. The preference pointer lives here and moves
// to the other requester whenever a grant is issued.
module sync_tx_arbiter_rr_arb2 (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [1:0] valid,   // bit 0 = A, bit 1 = B
  input  logic       enable,
  output logic [1:0] grant    // one-hot, bit 0 = A, bit 1 = B
);

  logic ptr_q;  // 0: A preferred on contention, 1: B preferred

  // Grant the lone requester, or the preferred one when both are valid.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // Point at the requester that did not win; ready is given only to a valid
  // requester, so any grant is an accepted handshake.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      ptr_q <= 1'b0;
    end else if (grant != 2'b00) begin
      ptr_q <= grant[0];
    end
  end

endmodule

// File: rtl/sync_tx_arbiter.sv
// Source-domain controller for a toggle-based data synchronizer channel shared by
// two requesters. Each accepted word goes onto tx_bus, tx_toggle flips one cycle later,
// and the bus is then held for HOLD_CYCLES so the destination can capture it.
module sync_tx_arbiter
  import sync_tx_arbiter_pkg::*;
#(
  parameter int unsigned Width       = 8,
  parameter int unsigned HOLD_CYCLES = 8   // >= 1
) (
  input logic              CLK,
  input logic              Reset,
  sync_tx_arbiter_if.slave bus
);

  localparam int unsigned CntW = clog2(HOLD_CYCLES + 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);

  state_e           state_q;
  logic [CntW-1:0]  hold_cnt_q;
  logic [Width-1:0] tx_bus_q;
  logic             tx_toggle_q;
  logic             busy_q;
  logic             last_src_q;

  logic [1:0]       grant;
  logic             arb_enable;

  assign arb_enable = (state_q == StIdle);

  sync_tx_arbiter_rr_arb2 u_rr_arb2 (
    .CLK    (CLK),
    .Reset  (Reset),
    .valid  ({bus.b_valid, bus.a_valid}),
    .enable (arb_enable),
    .grant  (grant)
  );

  // Ready is combinational from the grant; it is only ever raised in idle.
  always_comb begin
    bus.a_ready   = grant[0];
    bus.b_ready   = grant[1];
    bus.tx_bus    = tx_bus_q;
    bus.tx_toggle = tx_toggle_q;
    bus.busy      = busy_q;
    bus.last_src  = last_src_q;
  end

  // Transfer sequencer with registered outputs; tx_bus only moves on an accept edge
  // and tx_toggle only on the launch edge, so the bus always leads the toggle.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StIdle;
      hold_cnt_q  <= '0;
      tx_bus_q    <= '0;
      tx_toggle_q <= 1'b0;
      busy_q      <= 1'b0;
      last_src_q  <= SrcA;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant[0]) begin
            tx_bus_q   <= bus.a_data;
            last_src_q <= SrcA;
            busy_q     <= 1'b1;
            state_q    <= StLaunch;
          end else if (grant[1]) begin
            tx_bus_q   <= bus.b_data;
            last_src_q <= SrcB;
            busy_q     <= 1'b1;
            state_q    <= StLaunch;
          end
        end
        StLaunch: begin
          tx_toggle_q <= ~tx_toggle_q;
          hold_cnt_q  <= '0;
          state_q     <= StHold;
        end
        StHold: begin
          if (hold_cnt_q == HoldLast) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            hold_cnt_q <= hold_cnt_q + CntW'(1);
          end
        end
        default: begin
          // Unreachable encoding: recover to idle.
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_tx_arbiter.sv
// Directed bench for sync_tx_arbiter: a default build and a HOLD_CYCLES=1 build.
module tb_sync_tx_arbiter;

  logic CLK;
  logic Reset;
  int   errors;
  int   checks;
  logic exp_tog;
  logic exp_tog1;

  sync_tx_arbiter_if #(.Width(8)) bus ();
  sync_tx_arbiter_if #(.Width(8)) bus1 ();

  sync_tx_arbiter #(.Width(8), .HOLD_CYCLES(8)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  sync_tx_arbiter #(.Width(8), .HOLD_CYCLES(1)) dut1 (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    bus.a_valid = 1'b0; bus.a_data = 8'h00; bus.b_valid = 1'b0; bus.b_data = 8'h00;
    bus1.a_valid = 1'b0; bus1.a_data = 8'h00; bus1.b_valid = 1'b0; bus1.b_data = 8'h00;
    repeat (3) tick;
    Reset = 1'b1;
    tick;
    exp_tog = 1'b0;
    exp_tog1 = 1'b0;
    checks++; if (bus.tx_bus !== 8'h00) begin errors++; $display("FAIL reset_tx_bus: got %h want 00", bus.tx_bus); end
    checks++; if (bus.tx_toggle !== 1'b0) begin errors++; $display("FAIL reset_tx_toggle: got %b want 0", bus.tx_toggle); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.last_src !== 1'b0) begin errors++; $display("FAIL reset_last_src: got %b want 0", bus.last_src); end
    checks++; if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got a=%b b=%b want 0 0", bus.a_ready, bus.b_ready);
    end
    checks++; if (bus1.busy !== 1'b0 || bus1.tx_toggle !== 1'b0) begin
      errors++; $display("FAIL reset_hold1: got busy=%b tog=%b want 0 0", bus1.busy, bus1.tx_toggle);
    end
  endtask

  task automatic test_single_a;
    bus.a_valid = 1'b1; bus.a_data = 8'hA5;
    #1;
    checks++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      errors++; $display("FAIL single_ready: got a=%b b=%b want 1 0", bus.a_ready, bus.b_ready);
    end
    tick;  // cycle 1
    bus.a_valid = 1'b0; bus.a_data = 8'hFF;
    checks++; if (bus.tx_bus !== 8'hA5 || bus.tx_toggle !== exp_tog || bus.busy !== 1'b1) begin
      errors++; $display("FAIL single_c1: got bus=%h tog=%b busy=%b want A5 %b 1", bus.tx_bus, bus.tx_toggle, bus.busy, exp_tog);
    end
    exp_tog = ~exp_tog;
    for (int c = 2; c <= 9; c++) begin
      tick;
      checks++; if (bus.tx_bus !== 8'hA5 || bus.tx_toggle !== exp_tog || bus.busy !== 1'b1) begin
        errors++; $display("FAIL single_hold c%0d: got bus=%h tog=%b busy=%b want A5 %b 1", c, bus.tx_bus, bus.tx_toggle, bus.busy, exp_tog);
      end
    end
    tick;  // cycle 10
    checks++; if (bus.busy !== 1'b0 || bus.last_src !== 1'b0 || bus.tx_bus !== 8'hA5) begin
      errors++; $display("FAIL single_idle: got busy=%b src=%b bus=%h want 0 0 A5", bus.busy, bus.last_src, bus.tx_bus);
    end
  endtask

  task automatic test_valid_while_busy;
    bus.a_valid = 1'b1; bus.a_data = 8'h3C;
    #1;
    checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL vwb_a_ready: got %b want 1", bus.a_ready); end
    for (int c = 1; c <= 9; c++) begin
      tick;
      if (c == 1) bus.a_valid = 1'b0;
      if (c == 2) exp_tog = ~exp_tog;
      if (c == 3) begin bus.b_valid = 1'b1; bus.b_data = 8'h5A; end
      #1;
      checks++; if (bus.b_ready !== 1'b0 || bus.tx_bus !== 8'h3C || bus.tx_toggle !== exp_tog) begin
        errors++; $display("FAIL vwb_busy c%0d: got rdy=%b bus=%h tog=%b want 0 3C %b", c, bus.b_ready, bus.tx_bus, bus.tx_toggle, exp_tog);
      end
    end
    tick;  // cycle 10
    checks++; if (bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0) begin
      errors++; $display("FAIL vwb_b_accept: got a=%b b=%b want 0 1", bus.a_ready, bus.b_ready);
    end
    tick;  // cycle 11
    bus.b_valid = 1'b0;
    checks++; if (bus.tx_bus !== 8'h5A || bus.last_src !== 1'b1) begin
      errors++; $display("FAIL vwb_b_word: got bus=%h src=%b want 5A 1", bus.tx_bus, bus.last_src);
    end
    tick;  // cycle 12
    exp_tog = ~exp_tog;
    checks++; if (bus.tx_toggle !== exp_tog) begin errors++; $display("FAIL vwb_b_toggle: got %b want %b", bus.tx_toggle, exp_tog); end
    repeat (8) tick;  // cycle 20
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL vwb_idle: got %b want 0", bus.busy); end
  endtask

  task automatic test_contention;
    logic       exp_b;
    logic [7:0] exp_word;
    bus.a_valid = 1'b1; bus.a_data = 8'h11;
    bus.b_valid = 1'b1; bus.b_data = 8'h22;
    for (int k = 0; k < 4; k++) begin
      exp_b = ((k % 2) == 1);
      exp_word = exp_b ? 8'h22 : 8'h11;
      #1;
      checks++; if (bus.a_ready !== ~exp_b || bus.b_ready !== exp_b) begin
        errors++; $display("FAIL cont_grant k%0d: got a=%b b=%b want %b %b", k, bus.a_ready, bus.b_ready, ~exp_b, exp_b);
      end
      tick;
      checks++; if (bus.tx_bus !== exp_word || bus.last_src !== exp_b || bus.busy !== 1'b1) begin
        errors++; $display("FAIL cont_word k%0d: got bus=%h src=%b busy=%b want %h %b 1", k, bus.tx_bus, bus.last_src, bus.busy, exp_word, exp_b);
      end
      tick;
      exp_tog = ~exp_tog;
      checks++; if (bus.tx_toggle !== exp_tog || bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
        errors++; $display("FAIL cont_flip k%0d: got tog=%b a=%b b=%b want %b 0 0", k, bus.tx_toggle, bus.a_ready, bus.b_ready, exp_tog);
      end
      repeat (8) tick;
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
  endtask

  task automatic test_reset_mid_hold;
    bus.a_valid = 1'b1; bus.a_data = 8'h77;
    #1;
    checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_accept: got %b want 1", bus.a_ready); end
    tick;
    bus.a_valid = 1'b0;
    repeat (4) tick;  // cycle 5
    checks++; if (bus.busy !== 1'b1 || bus.tx_bus !== 8'h77) begin
      errors++; $display("FAIL rst_mid_pre: got busy=%b bus=%h want 1 77", bus.busy, bus.tx_bus);
    end
    #2;
    Reset = 1'b0;
    #1;
    exp_tog = 1'b0;
    exp_tog1 = 1'b0;
    checks++; if (bus.tx_bus !== 8'h00 || bus.tx_toggle !== 1'b0 || bus.busy !== 1'b0 || bus.last_src !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async: got bus=%h tog=%b busy=%b src=%b want 00 0 0 0", bus.tx_bus, bus.tx_toggle, bus.busy, bus.last_src);
    end
    @(negedge CLK);
    Reset = 1'b1;
    tick;
    bus.a_valid = 1'b1; bus.a_data = 8'h99;
    bus.b_valid = 1'b1; bus.b_data = 8'h66;
    #1;
    checks++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_a_first: got a=%b b=%b want 1 0", bus.a_ready, bus.b_ready);
    end
    tick;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    checks++; if (bus.tx_bus !== 8'h99 || bus.last_src !== 1'b0) begin
      errors++; $display("FAIL rst_mid_word: got bus=%h src=%b want 99 0", bus.tx_bus, bus.last_src);
    end
    repeat (9) tick;  // cycle 10
    exp_tog = ~exp_tog;
    checks++; if (bus.busy !== 1'b0 || bus.tx_toggle !== exp_tog) begin
      errors++; $display("FAIL rst_mid_idle: got busy=%b tog=%b want 0 %b", bus.busy, bus.tx_toggle, exp_tog);
    end
  endtask

  task automatic test_hold_one;
    logic [7:0] word;
    bus1.a_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      word = 8'h10 + 8'(k);
      bus1.a_data = word;
      #1;
      checks++; if (bus1.a_ready !== 1'b1 || bus1.busy !== 1'b0) begin
        errors++; $display("FAIL h1_accept k%0d: got rdy=%b busy=%b want 1 0", k, bus1.a_ready, bus1.busy);
      end
      tick;
      checks++; if (bus1.tx_bus !== word || bus1.busy !== 1'b1 || bus1.tx_toggle !== exp_tog1) begin
        errors++; $display("FAIL h1_launch k%0d: got bus=%h busy=%b tog=%b want %h 1 %b", k, bus1.tx_bus, bus1.busy, bus1.tx_toggle, word, exp_tog1);
      end
      tick;
      exp_tog1 = ~exp_tog1;
      checks++; if (bus1.tx_toggle !== exp_tog1 || bus1.a_ready !== 1'b0 || bus1.busy !== 1'b1) begin
        errors++; $display("FAIL h1_hold k%0d: got tog=%b rdy=%b busy=%b want %b 0 1", k, bus1.tx_toggle, bus1.a_ready, bus1.busy, exp_tog1);
      end
      tick;
    end
    bus1.a_valid = 1'b0;
    #1;
    checks++; if (bus1.busy !== 1'b0 || bus1.tx_bus !== 8'h12) begin
      errors++; $display("FAIL h1_idle: got busy=%b bus=%h want 0 12", bus1.busy, bus1.tx_bus);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset;
    test_single_a;
    test_valid_while_busy;
    test_contention;
    test_reset_mid_hold;
    test_hold_one;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
